vga_frame_scanner: RTL and testbench

Downstream display stage of the ASIP. Generates 640x480@60 Hz VGA timing from the 50 MHz system clock. Reads the processed image out of data RAM (one pixel per 32-bit word, 0x00RRGGBB) through a synchronous read port. Drives rgb, h_sync, v_sync and vga_clk to the board DAC.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_timing_counter.sv | 82 ++++++++
 rtl/vga_frame_scanner.sv | 109 ++++++++++
 tb/tb_vga_frame_scanner.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants and pixel type shared by the display stage.
// Both modules import this package.
package vga_pkg;
  localparam int S  = 32;
  // Counter width: holds a line length and a frame height of up to 4095.
  localparam int CW = 12;

  localparam int H_VIS     = 640;
  localparam int H_FP      = 16;
  localparam int H_SP      = 96;
  localparam int H_BP      = 48;
  localparam int V_VIS     = 480;
  localparam int V_FP      = 10;
  localparam int V_SP      = 2;
  localparam int V_BP      = 33;
  localparam int IMG_W     = 100;
  localparam int IMG_H     = 100;
  localparam int BASE_ADDR = 30000;

  localparam int H_TOT    = H_VIS + H_FP + H_SP + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SP + V_BP;
  localparam int HS_START = H_VIS + H_FP;
  localparam int HS_END   = HS_START + H_SP - 1;
  localparam int VS_START = V_VIS + V_FP;
  localparam int VS_END   = VS_START + V_SP - 1;

  typedef logic [23:0] pixel_t;

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/vga_timing_counter.sv
// Pixel-enable divider and the h/v scan counters.
// Produces the region flags and the frame markers for the current pixel.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int HVis = H_VIS,
  parameter int HFp  = H_FP,
  parameter int HSp  = H_SP,
  parameter int HBp  = H_BP,
  parameter int VVis = V_VIS,
  parameter int VFp  = V_FP,
  parameter int VSp  = V_SP,
  parameter int VBp  = V_BP,
  parameter int ImgW = IMG_W,
  parameter int ImgH = IMG_H
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic pix_en_o,
  output logic vga_clk_o,
  output logic in_img_o,
  output logic hs_n_o,
  output logic vs_n_o,
  output logic frame_start_o,
  output logic frame_last_o
);
  localparam int HTot = HVis + HFp + HSp + HBp;
  localparam int VTot = VVis + VFp + VSp + VBp;

  localparam logic [CW-1:0] HLast   = CW'(HTot - 1);
  localparam logic [CW-1:0] VLast   = CW'(VTot - 1);
  localparam logic [CW-1:0] HsLo    = CW'(HVis + HFp);
  localparam logic [CW-1:0] HsHi    = CW'(HVis + HFp + HSp - 1);
  localparam logic [CW-1:0] VsLo    = CW'(VVis + VFp);
  localparam logic [CW-1:0] VsHi    = CW'(VVis + VFp + VSp - 1);
  // An image larger than the visible area is clipped to it.
  localparam logic [CW-1:0] ImgWEff = CW'(minInt(ImgW, HVis));
  localparam logic [CW-1:0] ImgHEff = CW'(minInt(ImgH, VVis));

  logic          pix_en_q, pix_en_d;
  logic          vga_clk_q, vga_clk_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;

  // Each pixel spans two clk: the counters step only when pix_en is set.
  always_comb begin
    pix_en_d  = ~pix_en_q;
    vga_clk_d = pix_en_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (pix_en_q) begin
      if (h_cnt_q == HLast) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + CW'(1);
      end else begin
        h_cnt_d = h_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_en_q  <= 1'b0;
      vga_clk_q <= 1'b1;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
    end else begin
      pix_en_q  <= pix_en_d;
      vga_clk_q <= vga_clk_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
    end
  end

  assign pix_en_o      = pix_en_q;
  assign vga_clk_o     = vga_clk_q;
  assign in_img_o      = (h_cnt_q < ImgWEff) && (v_cnt_q < ImgHEff);
  assign hs_n_o        = !((h_cnt_q >= HsLo) && (h_cnt_q <= HsHi));
  assign vs_n_o        = !((v_cnt_q >= VsLo) && (v_cnt_q <= VsHi));
  assign frame_start_o = pix_en_q && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign frame_last_o  = pix_en_q && (h_cnt_q == HLast) && (v_cnt_q == VLast);
endmodule

// File: rtl/vga_frame_scanner.sv
// VGA display stage: reads the image linearly from data RAM and drives the DAC.
// Output path: colour, syncs and pixel clock, with a two-clk read pipeline.
module vga_frame_scanner
  import vga_pkg::*;
#(
  parameter int HVis     = H_VIS,
  parameter int HFp      = H_FP,
  parameter int HSp      = H_SP,
  parameter int HBp      = H_BP,
  parameter int VVis     = V_VIS,
  parameter int VFp      = V_FP,
  parameter int VSp      = V_SP,
  parameter int VBp      = V_BP,
  parameter int ImgW     = IMG_W,
  parameter int ImgH     = IMG_H,
  parameter int BaseAddr = BASE_ADDR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [S-1:0] mem_rdata,
  output logic [S-1:0] mem_addr,
  output logic         mem_rd_en,
  output logic         frame_start,
  output pixel_t       rgb,
  output logic         h_sync,
  output logic         v_sync,
  output logic         vga_clk
);
  localparam logic [S-1:0] Base = S'(BaseAddr);

  logic         pix_en, in_img, hs_n, vs_n, frame_last;
  logic [S-1:0] addr_q, addr_d;
  logic         img_p_q, img_p_d;
  logic         hs_p_q, hs_p_d;
  logic         vs_p_q, vs_p_d;
  pixel_t       rgb_q, rgb_d;
  logic         h_sync_q, h_sync_d;
  logic         v_sync_q, v_sync_d;
  logic         unused_rdata_hi;

  vga_timing_counter #(
    .HVis(HVis), .HFp(HFp), .HSp(HSp), .HBp(HBp),
    .VVis(VVis), .VFp(VFp), .VSp(VSp), .VBp(VBp),
    .ImgW(ImgW), .ImgH(ImgH)
  ) u_timing (
    .clk_i        (clk),
    .rst_ni       (rst),
    .pix_en_o     (pix_en),
    .vga_clk_o    (vga_clk),
    .in_img_o     (in_img),
    .hs_n_o       (hs_n),
    .vs_n_o       (vs_n),
    .frame_start_o(frame_start),
    .frame_last_o (frame_last)
  );

  // The base is reloaded on the frame's last pixel so that (0,0) already
  // presents BASE_ADDR and line 0 reads BASE_ADDR.. without a repeated word.
  always_comb begin
    addr_d   = addr_q;
    img_p_d  = img_p_q;
    hs_p_d   = hs_p_q;
    vs_p_d   = vs_p_q;
    rgb_d    = rgb_q;
    h_sync_d = h_sync_q;
    v_sync_d = v_sync_q;
    if (pix_en) begin
      img_p_d = in_img;
      hs_p_d  = hs_n;
      vs_p_d  = vs_n;
      if (frame_last) begin
        addr_d = Base;
      end else if (in_img) begin
        addr_d = addr_q + S'(1);
      end
    end else begin
      rgb_d    = img_p_q ? mem_rdata[23:0] : '0;
      h_sync_d = hs_p_q;
      v_sync_d = vs_p_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= Base;
      img_p_q  <= 1'b0;
      hs_p_q   <= 1'b1;
      vs_p_q   <= 1'b1;
      rgb_q    <= '0;
      h_sync_q <= 1'b1;
      v_sync_q <= 1'b1;
    end else begin
      addr_q   <= addr_d;
      img_p_q  <= img_p_d;
      hs_p_q   <= hs_p_d;
      vs_p_q   <= vs_p_d;
      rgb_q    <= rgb_d;
      h_sync_q <= h_sync_d;
      v_sync_q <= v_sync_d;
    end
  end

  assign unused_rdata_hi = ^mem_rdata[S-1:24];
  assign mem_addr  = addr_q;
  assign mem_rd_en = pix_en && in_img;
  assign rgb       = rgb_q;
  assign h_sync    = h_sync_q;
  assign v_sync    = v_sync_q;
endmodule

// File: tb/tb_vga_frame_scanner.sv
// Self-checking bench: a full-size scanner for line timing and addressing and
// a shrunken, clipped one for frame timing and mid-frame reset, both against a model.
module tb_vga_frame_scanner;
  typedef struct {
    int hVis, hFp, hSp, hBp, vVis, vFp, vSp, vBp, imgW, imgH, base;
  } geom_t;

  typedef struct {
    logic        vgaClk, rdEn, fs, hs, vs, addrKnown;
    logic [23:0] rgb;
    logic [31:0] addr;
  } expect_t;

  geom_t gFull  = '{640, 16, 96, 48, 480, 10, 2, 33, 100, 100, 30000};
  geom_t gSmall = '{16, 2, 3, 3, 12, 1, 2, 2, 20, 5, 1000};

  logic        clk = 1'b0;
  logic        rstFull, rstSmall;
  logic [31:0] fullRdata, smallRdata, fullAddr, smallAddr;
  logic        fullRdEn, fullFs, fullHs, fullVs, fullVclk;
  logic        smallRdEn, smallFs, smallHs, smallVs, smallVclk;
  logic [23:0] fullRgb, smallRgb;

  int assertCount = 0;
  int failCount   = 0;
  int nFull, nSmall;
  bit chkFull  = 0;
  bit chkSmall = 0;
  int smallPhase = 0;
  logic prevFullHs = 1'b1, prevSmallVs = 1'b1;
  int fullHsFall[$], fullHsRise[$], smallVsFall[$], smallVsRise[$], smallFsAt[$];
  logic [31:0] capAddr99 = '1, capRdEn100 = '1, capRgb100 = '1, capAddrLine1 = '1, capRgb51 = '1;
  logic [31:0] capClipRdEn = '1, capLastAddr = '1, capWrapAddr = '1, capRestartAddr = '1;

  always #10 clk = ~clk;

  vga_frame_scanner dutFull (
    .clk(clk), .rst(rstFull), .mem_rdata(fullRdata), .mem_addr(fullAddr),
    .mem_rd_en(fullRdEn), .frame_start(fullFs), .rgb(fullRgb),
    .h_sync(fullHs), .v_sync(fullVs), .vga_clk(fullVclk)
  );

  vga_frame_scanner #(
    .HVis(16), .HFp(2), .HSp(3), .HBp(3), .VVis(12), .VFp(1), .VSp(2), .VBp(2),
    .ImgW(20), .ImgH(5), .BaseAddr(1000)
  ) dutSmall (
    .clk(clk), .rst(rstSmall), .mem_rdata(smallRdata), .mem_addr(smallAddr),
    .mem_rd_en(smallRdEn), .frame_start(smallFs), .rgb(smallRgb),
    .h_sync(smallHs), .v_sync(smallVs), .vga_clk(smallVclk)
  );

  // Synchronous-read RAMs whose word holds its own address; junk while in reset.
  always @(posedge clk) begin
    if (!rstFull) fullRdata <= $urandom;
    else if (fullRdEn) fullRdata <= {8'hAA, fullAddr[23:0]};
  end

  always @(posedge clk) begin
    if (!rstSmall) smallRdata <= $urandom;
    else if (smallRdEn) smallRdata <= {8'($urandom), smallAddr[23:0]};
  end

  always @(posedge clk or negedge rstFull) begin
    if (!rstFull) nFull <= 0;
    else nFull <= nFull + 1;
  end

  always @(posedge clk or negedge rstSmall) begin
    if (!rstSmall) nSmall <= 0;
    else nSmall <= nSmall + 1;
  end

  // n = clk edges since reset release. Pixel q owns the pix_en cycle after
  // edge 2q+1; its colour and syncs appear after edge 2q+3 and hold two clk.
  function automatic expect_t predict(input geom_t g, input int n);
    expect_t e;
    int hTot, vTot, frame, ew, eh, q, h, v;
    hTot  = g.hVis + g.hFp + g.hSp + g.hBp;
    vTot  = g.vVis + g.vFp + g.vSp + g.vBp;
    frame = hTot * vTot;
    ew    = (g.imgW < g.hVis) ? g.imgW : g.hVis;
    eh    = (g.imgH < g.vVis) ? g.imgH : g.vVis;
    e.vgaClk    = (n % 2 == 0);
    e.rdEn      = 1'b0;
    e.fs        = 1'b0;
    e.addrKnown = (n == 0);
    e.addr      = 32'(g.base);
    e.rgb       = '0;
    e.hs        = 1'b1;
    e.vs        = 1'b1;
    if (n % 2 == 1) begin
      q = ((n - 1) / 2) % frame;
      h = q % hTot;
      v = q / hTot;
      e.fs = (q == 0);
      if (h < ew && v < eh) begin
        e.rdEn      = 1'b1;
        e.addrKnown = 1'b1;
        e.addr      = 32'(g.base + v * ew + h);
      end
    end
    if (n >= 3) begin
      q = ((n - 3) / 2) % frame;
      h = q % hTot;
      v = q / hTot;
      if (h < ew && v < eh) e.rgb = 24'(g.base + v * ew + h);
      e.hs = !(h >= g.hVis + g.hFp && h < g.hVis + g.hFp + g.hSp);
      e.vs = !(v >= g.vVis + g.vFp && v < g.vVis + g.vFp + g.vSp);
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkCycle(input string pre, input geom_t g, input int n,
                            input logic vclk, input logic rdEn, input logic fs,
                            input logic hs, input logic vs, input logic [23:0] rgb,
                            input logic [31:0] addr);
    expect_t e;
    e = predict(g, n);
    checkOutput($sformatf("%s.vga_clk n=%0d", pre, n), 32'(vclk), 32'(e.vgaClk));
    checkOutput($sformatf("%s.mem_rd_en n=%0d", pre, n), 32'(rdEn), 32'(e.rdEn));
    checkOutput($sformatf("%s.frame_start n=%0d", pre, n), 32'(fs), 32'(e.fs));
    checkOutput($sformatf("%s.h_sync n=%0d", pre, n), 32'(hs), 32'(e.hs));
    checkOutput($sformatf("%s.v_sync n=%0d", pre, n), 32'(vs), 32'(e.vs));
    checkOutput($sformatf("%s.rgb n=%0d", pre, n), 32'(rgb), 32'(e.rgb));
    if (e.addrKnown)
      checkOutput($sformatf("%s.mem_addr n=%0d", pre, n), addr, e.addr);
  endtask

  always @(negedge clk) begin
    if (chkFull) begin
      checkCycle("full", gFull, nFull, fullVclk, fullRdEn, fullFs, fullHs, fullVs,
                 fullRgb, fullAddr);
      if (prevFullHs && !fullHs) fullHsFall.push_back(nFull);
      if (!prevFullHs && fullHs) fullHsRise.push_back(nFull);
      prevFullHs = fullHs;
      if (nFull == 199)  capAddr99    = fullAddr;
      if (nFull == 201)  capRdEn100   = 32'(fullRdEn);
      if (nFull == 203)  capRgb100    = 32'(fullRgb);
      if (nFull == 1601) capAddrLine1 = fullAddr;
      if (nFull == 1613) capRgb51     = 32'(fullRgb);
    end
  end

  always @(negedge clk) begin
    if (chkSmall) begin
      checkCycle("small", gSmall, nSmall, smallVclk, smallRdEn, smallFs, smallHs,
                 smallVs, smallRgb, smallAddr);
      if (smallFs) smallFsAt.push_back(nSmall);
      if (smallPhase == 0) begin
        if (prevSmallVs && !smallVs) smallVsFall.push_back(nSmall);
        if (!prevSmallVs && smallVs) smallVsRise.push_back(nSmall);
        prevSmallVs = smallVs;
        if (nSmall == 33)  capClipRdEn = 32'(smallRdEn);
        if (nSmall == 223) capLastAddr = smallAddr;
        if (nSmall == 817) capWrapAddr = smallAddr;
      end else if (nSmall == 1) begin
        capRestartAddr = smallAddr;
      end
    end
  end

  task automatic applyStimulus();
    int k, target, waited;
    rstFull  = 1'b1;
    rstSmall = 1'b1;
    #1;
    rstFull  = 1'b0;
    rstSmall = 1'b0;
    chkFull  = 1;
    chkSmall = 1;
    repeat (5) @(negedge clk);
    rstFull  = 1'b1;
    rstSmall = 1'b1;
    repeat (3 * 1600 + 100) @(negedge clk);
    chkFull = 0;
    rstFull = 1'b0;

    // Random point inside line 8 of a later small frame, then an async reset.
    k      = ((nSmall / 816) + 1) * 816;
    target = k + 2 * (8 * 24 + int'($urandom_range(23, 0))) + 1 + int'($urandom_range(1, 0));
    waited = 0;
    while (nSmall < target && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("midframe.reached", 32'(nSmall >= target), 32'd1);
    #3;
    rstSmall   = 1'b0;
    smallPhase = 1;
    smallFsAt.delete();
    #1;
    checkOutput("midframe.rgb", 32'(smallRgb), 32'd0);
    checkOutput("midframe.h_sync", 32'(smallHs), 32'd1);
    checkOutput("midframe.v_sync", 32'(smallVs), 32'd1);
    checkOutput("midframe.vga_clk", 32'(smallVclk), 32'd1);
    checkOutput("midframe.mem_rd_en", 32'(smallRdEn), 32'd0);
    checkOutput("midframe.mem_addr", smallAddr, 32'd1000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstSmall = 1'b1;
    repeat (900) @(negedge clk);
    chkSmall = 0;
  endtask

  task automatic checkOutput_summary();
    checkOutput("line.hsFallFirst", 32'(fullHsFall[0]), 32'd1315);
    checkOutput("line.hsPeriod01", 32'(fullHsFall[1] - fullHsFall[0]), 32'd1600);
    checkOutput("line.hsPeriod12", 32'(fullHsFall[2] - fullHsFall[1]), 32'd1600);
    checkOutput("line.hsLowWidth", 32'(fullHsRise[0] - fullHsFall[0]), 32'd192);
    checkOutput("addr.pixel99_0", capAddr99, 32'd30099);
    checkOutput("addr.pixel100_0.rd_en", capRdEn100, 32'd0);
    checkOutput("rgb.pixel100_0", capRgb100, 32'd0);
    checkOutput("addr.line1Start", capAddrLine1, 32'd30100);
    checkOutput("rgb.pixel5_1", capRgb51, 32'd30105);
    checkOutput("frame.vsFallFirst", 32'(smallVsFall[0]), 32'(2 * 13 * 24 + 3));
    checkOutput("frame.vsPeriod", 32'(smallVsFall[1] - smallVsFall[0]), 32'(2 * 24 * 17));
    checkOutput("frame.vsLowWidth", 32'(smallVsRise[0] - smallVsFall[0]), 32'(2 * 2 * 24));
    checkOutput("clip.pixel16_0.rd_en", capClipRdEn, 32'd0);
    checkOutput("addr.lastImagePixel", capLastAddr, 32'(1000 + 4 * 16 + 15));
    checkOutput("addr.nextFrame", capWrapAddr, 32'd1000);
    checkOutput("reset.fsFirst", 32'(smallFsAt[0]), 32'd1);
    checkOutput("reset.fsPeriod", 32'(smallFsAt[1] - smallFsAt[0]), 32'(2 * 24 * 17));
    checkOutput("reset.firstRead", capRestartAddr, 32'd1000);
  endtask

  initial begin
    applyStimulus();
    checkOutput_summary();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
